// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (CPU port) and the external loader (EXT port).
// The CPU has fixed priority. A streak limit guarantees that a waiting EXT
// request is eventually granted.
// Memory latency is variable and is tolerated through a mem_req / mem_ack handshake.
// Optional feature macro: DMEM_ARB_TIMEOUT_EN aborts an access after TIMEOUT
// cycles without mem_ack. The abort pulses done and err together.
//
// Handshake: a requester raises *_req with stable we/addr/wdata and holds it
// until its one-cycle *_done pulse. The memory sees mem_req high with stable
// mem_we/mem_addr/mem_wdata until it returns a single-cycle mem_ack. mem_rdata
// is valid only with mem_ack.
module dmem_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int MAX_CPU_STREAK = 4,
  parameter int TIMEOUT        = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  if (MAX_CPU_STREAK < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("dmem_arbiter: MAX_CPU_STREAK and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, CPU_ACC, EXT_ACC} state_t;

  localparam int SW = $clog2(MAX_CPU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic          grant_cpu, grant_ext;
  logic          in_acc, finish, abort, hold_off;

  // The done cycle is still an IDLE cycle, but the finishing requester still
  // holds its req during that cycle. Granting nothing in that cycle prevents
  // the same request from being served twice.
  assign hold_off  = cpu_done | ext_done;
  assign in_acc    = (state != IDLE);
  assign mem_req   = in_acc;
  assign finish    = in_acc & (mem_ack | abort);
  assign cpu_stall = cpu_req & ~cpu_done;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer;
  logic          err_q;

  assign abort = in_acc & ~mem_ack & (timer == TMO_LAST);
  assign err   = err_q;

  // Count ACC cycles without an ack; an abort raises err alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (grant_cpu || grant_ext) timer <= '0;
      else if (in_acc && !mem_ack && !abort) timer <= timer + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and grant decision
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_ext = 1'b0;
    case (state)
      IDLE: begin
        if (!hold_off) begin
          if (ext_req && (!cpu_req || streak == STREAK_MAX)) begin
            grant_ext = 1'b1;
            state_nxt = EXT_ACC;
          end else if (cpu_req) begin
            grant_cpu = 1'b1;
            state_nxt = CPU_ACC;
          end
        end
      end
      CPU_ACC, EXT_ACC: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Streak of CPU grants that were made while EXT was waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (grant_ext || !ext_req)                     streak <= '0;
      else if (grant_cpu && streak != STREAK_MAX)    streak <= streak + 1'b1;
    end
  end

  // Latch the winner's request, return read data and issue done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
      cpu_done  <= 1'b0;
      ext_done  <= 1'b0;
    end else begin
      cpu_done <= finish & (state == CPU_ACC);
      ext_done <= finish & (state == EXT_ACC);
      if (grant_cpu) begin
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (grant_ext) begin
        mem_we    <= ext_we;
        mem_addr  <= ext_addr;
        mem_wdata <= ext_wdata;
      end
      if (finish && state == CPU_ACC) begin
        if (abort)        cpu_rdata <= '0;
        else if (!mem_we) cpu_rdata <= mem_rdata;
      end
      if (finish && state == EXT_ACC) begin
        if (abort)        ext_rdata <= '0;
        else if (!mem_we) ext_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by a randomized run.
// In the randomized run, a bench-side model of the memory, the requesters
// and the arbitration rules predicts every grant, done pulse and read value.
module tb_dmem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, ext_req, ext_we, mem_ack;
  logic [AW-1:0] cpu_addr, ext_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, ext_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          cpu_done, cpu_stall, ext_done, mem_req, mem_we, err;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_CPU_STREAK(MAX), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Single CPU access. The memory acks once ack_delay ACC cycles have passed
  // without an ack. The task counts mem_req and stall cycles and the cycle of
  // the done pulse.
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input int ack_delay, input logic [DW-1:0] rd,
                            output int req_cycles, output int stall_cycles,
                            output int done_at, output int err_cycles);
    req_cycles = 0; stall_cycles = 0; done_at = -1; err_cycles = 0;
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      if (mem_req) begin
        req_cycles++;
        check_eq("acc_mem_we", mem_we, we);
        check_eq("acc_mem_addr", mem_addr, addr);
        check_eq("acc_mem_wdata", mem_wdata, wdata);
      end
      mem_ack   = mem_req && (req_cycles == ack_delay + 1);
      mem_rdata = mem_ack ? rd : 32'h0;
      #1;
      if (cpu_stall) stall_cycles++;
      if (err) err_cycles++;
      if (cpu_done) done_at = k;
      tick();
    end
    mem_ack = 0;
    cpu_req = 0;
  endtask

  // Randomized-run model state
  logic [DW-1:0] mem_m [16];
  logic [DW-1:0] cpu_exp_q[$];
  logic [DW-1:0] ext_exp_q[$];
  logic [DW-1:0] cpu_last, ext_last, exp_v;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_we;
  bit  busy, win_ext, pend_cpu, pend_ext, cpu_fin, ext_fin, done_now, was_busy, g_cpu, g_ext;
  int  ack_wait, streak_m;
  int  rq, st, dn, ec, grants;
  bit  order_ext[$];

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_cpu_done", cpu_done, 0);
    check_eq("rst_ext_done", ext_done, 0);
    check_eq("rst_cpu_stall", cpu_stall, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    check_eq("rst_ext_rdata", ext_rdata, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_we", mem_we, 0);

    // CPU read, immediate ack
    cpu_access(0, 32'h40, 32'h0, 0, 32'hDEADBEEF, rq, st, dn, ec);
    check_eq("rd_req_cycles", rq, 1);
    check_eq("rd_done_at", dn, 2);
    check_eq("rd_stall_cycles", st, 2);
    check_eq("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check_eq("rd_cpu_done_low", cpu_done, 0);

    // CPU write, ack delayed by 3 cycles; rdata must keep the previous load
    cpu_access(1, 32'h80, 32'h12345678, 3, 32'hAAAA5555, rq, st, dn, ec);
    check_eq("wr_req_cycles", rq, 4);
    check_eq("wr_done_at", dn, 5);
    check_eq("wr_stall_cycles", st, 5);
    check_eq("wr_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);

    // No ack at all
    cpu_access(0, 32'hC0, 32'h0, 1000, 32'h0, rq, st, dn, ec);
`ifdef DMEM_ARB_TIMEOUT_EN
    check_eq("tmo_req_cycles", rq, 15);
    check_eq("tmo_done_at", dn, 16);
    check_eq("tmo_err_cycles", ec, 1);
    check_eq("tmo_cpu_rdata", cpu_rdata, 0);
`else
    check_eq("noack_done_at", dn, -1);
    check_eq("noack_req_cycles", rq, 39);
    check_eq("noack_err_cycles", ec, 0);
    check_eq("noack_mem_req", mem_req, 1);
`endif

    // Reset in the second cycle of an EXT access; a late ack is ignored
    do_reset();
    ext_req = 1; ext_we = 0; ext_addr = 32'h200;
    tick();
    check_eq("rstacc_mem_req1", mem_req, 1);
    tick();
    check_eq("rstacc_mem_req2", mem_req, 1);
    rst = 1;
    tick();
    rst = 0; ext_req = 0;
    check_eq("rstacc_mem_req_off", mem_req, 0);
    check_eq("rstacc_ext_done", ext_done, 0);
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ack = 0;
    check_eq("late_ack_ext_done", ext_done, 0);
    check_eq("late_ack_mem_req", mem_req, 0);
    tick();
    check_eq("late_ack_ext_done2", ext_done, 0);
    check_eq("late_ack_ext_rdata", ext_rdata, 0);

    // Both requests held, immediate ack: CPU x4 then EXT, repeating
    do_reset();
    cpu_req = 1; cpu_addr = 32'h100; ext_req = 1; ext_addr = 32'h200;
    for (int k = 0; k < 200 && order_ext.size() < 15; k++) begin
      if (mem_req) order_ext.push_back(mem_addr == 32'h200);
      mem_ack = mem_req;
      tick();
    end
    mem_ack = 0;
    check_eq("streak_grant_count", order_ext.size(), 15);
    for (int i = 0; i < order_ext.size(); i++)
      check_eq($sformatf("streak_grant_%0d_is_ext", i), order_ext[i], (i % 5) == 4);

    // Randomized run
    do_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom();
    busy = 0; pend_cpu = 0; pend_ext = 0; cpu_fin = 0; ext_fin = 0;
    streak_m = 0; ack_wait = 0; grants = 0;
    cpu_last = '0; ext_last = '0;
    acc_we = 0; acc_addr = '0; acc_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      check_eq("r_cpu_done", cpu_done, pend_cpu);
      check_eq("r_ext_done", ext_done, pend_ext);
      check_eq("r_mem_req", mem_req, busy);
      check_eq("r_err", err, 0);
      if (pend_cpu) begin
        exp_v = cpu_exp_q.pop_front();
        check_eq("r_cpu_rdata", cpu_rdata, exp_v);
      end
      if (pend_ext) begin
        exp_v = ext_exp_q.pop_front();
        check_eq("r_ext_rdata", ext_rdata, exp_v);
      end
      if (busy) begin
        check_eq("r_mem_we", mem_we, acc_we);
        check_eq("r_mem_addr", mem_addr, acc_addr);
        check_eq("r_mem_wdata", mem_wdata, acc_wdata);
      end
      done_now = pend_cpu | pend_ext;
      pend_cpu = 0; pend_ext = 0;
      was_busy = busy;

      // Memory: ack after a random latency; stray acks while idle
      mem_rdata = $urandom();
      mem_ack = 0;
      if (busy) begin
        if (ack_wait == 0) begin
          mem_ack = 1;
          if (acc_we) begin
            mem_m[acc_addr[5:2]] = acc_wdata;
            exp_v = win_ext ? ext_last : cpu_last;
          end else begin
            mem_rdata = mem_m[acc_addr[5:2]];
            exp_v = mem_rdata;
          end
          if (win_ext) begin ext_exp_q.push_back(exp_v); ext_last = exp_v; pend_ext = 1; end
          else         begin cpu_exp_q.push_back(exp_v); cpu_last = exp_v; pend_cpu = 1; end
          busy = 0;
        end else begin
          ack_wait--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
      end

      // Requesters: hold through done, then optionally issue a new request
      if (!cpu_req || cpu_fin) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_we = $urandom_range(0, 1); cpu_addr = $urandom(); cpu_wdata = $urandom();
      end
      if (!ext_req || ext_fin) begin
        ext_req = $urandom_range(0, 1);
        ext_we = $urandom_range(0, 1); ext_addr = $urandom(); ext_wdata = $urandom();
      end
      cpu_fin = cpu_done;
      ext_fin = ext_done;

      // Arbitration rule
      if (!was_busy) begin
        g_ext = !done_now && ext_req && (!cpu_req || streak_m == MAX);
        g_cpu = !done_now && !g_ext && cpu_req;
        if (!ext_req || g_ext)             streak_m = 0;
        else if (g_cpu && streak_m < MAX)  streak_m++;
        if (g_ext || g_cpu) begin
          busy = 1; win_ext = g_ext; grants++;
          acc_we    = g_ext ? ext_we    : cpu_we;
          acc_addr  = g_ext ? ext_addr  : cpu_addr;
          acc_wdata = g_ext ? ext_wdata : cpu_wdata;
          ack_wait  = $urandom_range(0, 3);
        end
      end
      #1;
      check_eq("r_cpu_stall", cpu_stall, cpu_req & ~cpu_done);
    end
    if (grants < 100) begin
      errors++;
      $display("FAIL r_grant_count: got %0d expected at least 100", grants);
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: the pipeline MEM stage (CPU port) and the external program/data loader (EXT port).
- Drives a cpu_stall that freezes the pipeline while a CPU access is outstanding.
- Sits between MEMStage and the data memory and tolerates variable-latency memory through a req/ack handshake.
- CPU has fixed priority, with a streak limit so the EXT port is never starved.

Parameters:
- DATA_W, 32, data word width (matches WORD_LEN)
- ADDR_W, 32, byte address width
- MAX_CPU_STREAK, 4, consecutive CPU grants allowed while EXT is waiting (>=1)
- TIMEOUT, 15, cycles without mem_ack before an access is aborted (only used with DMEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_done
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data, valid on cpu_done
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  freeze request to pipeline
- ext_req  in  1  loader request, held until ext_done
- ext_we  in  1  loader write enable
- ext_addr  in  ADDR_W  loader address
- ext_wdata  in  DATA_W  loader write data
- ext_rdata  out  DATA_W  loader read data, valid on ext_done
- ext_done  out  1  one-cycle completion pulse
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- err  out  1  one-cycle timeout pulse (0 without the optional feature)

Behaviour:
- Reset values: all outputs 0. State=IDLE, streak=0, timer=0.
- FSM states: IDLE, CPU_ACC, EXT_ACC.
- IDLE decision, evaluated every cycle:
  - grant EXT if ext_req and (!cpu_req or streak==MAX_CPU_STREAK);
  - else grant CPU if cpu_req;
  - else stay in IDLE.
- On grant: mem_we/mem_addr/mem_wdata are registered from the winner; next state is CPU_ACC or EXT_ACC.
- In ACC states:
  - mem_req=1; mem_we/mem_addr/mem_wdata are held stable.
  - On mem_ack: the winner's rdata register loads mem_rdata (on reads only; writes leave rdata unchanged). The winner's done pulses the next cycle. mem_req drops. State returns to IDLE.
- Minimum latency: request sampled in cycle N; mem_req high in N+1; ack in N+1 gives done in N+2. A requester can be re-granted no earlier than the cycle after done.
- Streak counter:
  - +1 on each CPU grant while ext_req=1, saturating at MAX_CPU_STREAK.
  - Cleared on EXT grant, or on any IDLE cycle with ext_req=0.
- cpu_stall = cpu_req & ~cpu_done. It is combinational, so the pipeline advances exactly in the cycle done pulses.
- Requester drops req mid-access: the access still completes and the done pulse is still issued. The requester ignores it.
- Simultaneous requests in IDLE with streak<MAX_CPU_STREAK: CPU wins.
- mem_ack outside an ACC state: ignored.
- rst mid-access: next cycle state=IDLE, mem_req=0, no done pulse, and the in-flight access is abandoned. The memory must tolerate a dropped mem_req.
- cpu_rdata and ext_rdata hold their last value between accesses.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN
- Defined:
  - timer counts ACC cycles without mem_ack;
  - if timer reaches TIMEOUT with no ack, the access is aborted: mem_req=0, the winner's rdata loads 0, done and err pulse together next cycle, state=IDLE;
  - timer clears on grant.
- Undefined: no timer; accesses wait indefinitely for mem_ack; err is tied to 0.

Test Plan:
- CPU read alone, cpu_addr=0x40, mem_ack in the first ACC cycle with mem_rdata=0xDEADBEEF -> mem_req high 1 cycle; cpu_done 2 cycles after req; cpu_rdata=0xDEADBEEF; cpu_stall high exactly 2 cycles.
- CPU write with ack delayed 3 cycles -> mem_we=1 and mem_addr/mem_wdata stable all 4 ACC cycles; cpu_stall held until cpu_done.
- cpu_req and ext_req held continuously, MAX_CPU_STREAK=4, ack immediate -> grant order CPU,CPU,CPU,CPU,EXT repeating; streak returns to 0 after each EXT grant.
- Both requests arrive in the same cycle with streak=0 -> CPU granted first; EXT granted at the next IDLE decision, after cpu_done.
- rst asserted in the second cycle of EXT_ACC (ack not yet seen) -> next cycle mem_req=0, ext_done=0, state IDLE; a later ack is ignored.
- With DMEM_ARB_TIMEOUT_EN, TIMEOUT=15, no ack -> after 15 ACC cycles cpu_done=1, err=1, cpu_rdata=0. Without the macro, mem_req stays high and err stays 0.
